// File: rtl/serial_pattern_tx.sv
// MSB-first serial transmitter driving the 0101/1010 detector d_in stream.
// Optional golden pattern counter enabled by SERIAL_TX_EXPECT_EN.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             d_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
`ifdef SERIAL_TX_EXPECT_EN
  ,
  output logic [CNT_W-1:0] exp_count
`endif
);

  localparam int DW = $clog2(DIV) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] shreg;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             accept;
  logic             advance;
  logic             finish;
  logic             period_end;

  assign load_ready = (state == IDLE);
  assign busy       = (state == SHIFT);
  assign period_end = (div_cnt == DIV_LAST);

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        accept = load_valid;
        if (load_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (period_end) begin
          if (bit_cnt == BIT_LAST) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // shreg holds the bits not yet driven, next one in the MSB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      d_out      <= 1'b0;
      bit_strobe <= 1'b0;
      done       <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      done       <= finish;
      if (accept) begin
        shreg      <= load_data << 1;
        d_out      <= load_data[WIDTH-1];
        bit_strobe <= 1'b1;
        div_cnt    <= '0;
        bit_cnt    <= '0;
      end else if (state == SHIFT) begin
        if (period_end) begin
          div_cnt <= '0;
          if (advance) begin
            bit_cnt    <= bit_cnt + 1'b1;
            d_out      <= shreg[WIDTH-1];
            shreg      <= shreg << 1;
            bit_strobe <= 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SERIAL_TX_EXPECT_EN
  logic [3:0] hist;
  logic [2:0] sent;
  logic       new_bit;
  logic       hit;

  assign new_bit = accept ? load_data[WIDTH-1] : shreg[WIDTH-1];
  assign hit     = (hist == 4'b0101) || (hist == 4'b1010);

  // sent saturates at 4: history is only meaningful once full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist      <= '0;
      sent      <= '0;
      exp_count <= '0;
    end else begin
      if (accept || advance) begin
        hist <= {hist[2:0], new_bit};
        if (!sent[2]) sent <= sent + 1'b1;
      end
      if (bit_strobe && sent[2] && hit && exp_count != '1)
        exp_count <= exp_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed + random bench for serial_pattern_tx (DIV=4 and DIV=1 instances).
// Define SERIAL_TX_EXPECT_EN to also check the golden pattern counter.
module tb_serial_pattern_tx;

  localparam int W  = 8;
  localparam int DV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready, d_out, bit_strobe, busy, done;
  logic       v1;
  logic [7:0] data1;
  logic       r1, d1, s1, b1, done1;
`ifdef SERIAL_TX_EXPECT_EN
  logic [7:0] exp_count;
  logic [7:0] exp1;
`endif

  int checks = 0;
  int errors = 0;
  bit sent_q[$];
  logic last_bit;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(W), .DIV(DV), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .d_out(d_out),
    .bit_strobe(bit_strobe), .busy(busy), .done(done)
`ifdef SERIAL_TX_EXPECT_EN
    , .exp_count(exp_count)
`endif
  );

  serial_pattern_tx #(.WIDTH(W), .DIV(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset),
    .load_valid(v1), .load_data(data1),
    .load_ready(r1), .d_out(d1),
    .bit_strobe(s1), .busy(b1), .done(done1)
`ifdef SERIAL_TX_EXPECT_EN
    , .exp_count(exp1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 3; i < sent_q.size(); i++) begin
      logic [3:0] p;
      p = {sent_q[i-3], sent_q[i-2], sent_q[i-1], sent_q[i]};
      if ((p == 4'b0101 || p == 4'b1010) && n < 255) n++;
    end
    return n;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"}, d_out, 1'b0);
    chk({tag, "_ready"}, load_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_strobe"}, bit_strobe, 1'b0);
  endtask

  // Called at the negedge after the accept edge; returns in the done cycle.
  task automatic check_stream(input logic [7:0] w, input logic hv,
                              input logic [7:0] hd);
    load_valid = hv;
    load_data  = hd;
    for (int k = 0; k < W * DV; k++) begin
      chk("bit", d_out, w[W-1-k/DV]);
      chk("strobe", bit_strobe, (k % DV) == 0);
      chk("busy", busy, 1'b1);
      chk("ready_low", load_ready, 1'b0);
      chk("no_done", done, 1'b0);
      if (k % DV == 0) sent_q.push_back(w[W-1-k/DV]);
      @(negedge clk);
    end
    chk("done", done, 1'b1);
    chk("done_ready", load_ready, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_strobe", bit_strobe, 1'b0);
    chk("hold_last", d_out, w[0]);
`ifdef SERIAL_TX_EXPECT_EN
    chk("exp_model", exp_count, model_count());
`endif
    last_bit = w[0];
  endtask

  task automatic send(input logic [7:0] w, input int gap);
    for (int g = 0; g < gap; g++) begin
      chk("idle_busy", busy, 1'b0);
      chk("idle_line", d_out, last_bit);
      @(negedge clk);
    end
    chk("ready", load_ready, 1'b1);
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    check_stream(w, 1'b0, 8'($urandom));
    @(negedge clk);
    chk("post_done", done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    v1         = 1'b0;
    data1      = '0;
    last_bit   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rel");

    // A5 while holding FF: FF must wait for the done edge
    load_valid = 1'b1;
    load_data  = 8'hA5;
    @(negedge clk);
    check_stream(8'hA5, 1'b1, 8'hFF);
    @(negedge clk);
    check_stream(8'hFF, 1'b0, 8'h00);
    @(negedge clk);

    // reset during bit 3 of 3C
    load_valid = 1'b1;
    load_data  = 8'h3C;
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < 14; k++) begin
      chk("mid_bit", d_out, 8'h3C >> (W - 1 - k / DV) & 1);
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1 chk_reset_vals("midrst");
    sent_q.delete();
    last_bit = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrel");
    send(8'hC3, 1);

    for (int n = 0; n < 6; n++)
      send(8'($urandom), int'($urandom_range(0, 3)));

    // DIV=1: valid held high, two words with one done cycle between
    @(negedge clk);
    v1    = 1'b1;
    data1 = 8'h0F;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < W; k++) begin
        chk("d1_bit", d1, data1[W-1-k]);
        chk("d1_strobe", s1, 1'b1);
        chk("d1_busy", b1, 1'b1);
        @(negedge clk);
      end
      chk("d1_done", done1, 1'b1);
      chk("d1_gap_strobe", s1, 1'b0);
      chk("d1_gap_busy", b1, 1'b0);
      chk("d1_gap_ready", r1, 1'b1);
      if (n == 1) v1 = 1'b0;
      @(negedge clk);
    end
    chk("d1_idle", b1, 1'b0);
    chk("d1_idle_line", d1, 1'b1);

`ifdef SERIAL_TX_EXPECT_EN
    reset = 1'b0;
    @(negedge clk);
    chk("exp_rst", exp_count, 8'd0);
    sent_q.delete();
    last_bit = 1'b0;
    reset = 1'b1;
    send(8'h5A, 1);
    chk("exp_5a", exp_count, 8'd2);
    send(8'h55, 0);
    chk("exp_55", exp_count, 8'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Parallel-to-serial bit-stream transmitter. Produces the d_in stream consumed by the team's Mealy 0101/1010 sequence detectors.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out MSB-first, holding each bit for DIV clocks, so the stream matches a slowed detector clock.
- Used as stimulus source on the board and in system benches.

Parameters:
- WIDTH, 8, bits per transmitted word (>=2).
- DIV, 4, clk cycles each bit is held on d_out (>=1).
- CNT_W, 8, width of exp_count (used only with the optional feature).

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- load_valid  in  1  load_data is valid.
- load_data  in  WIDTH  word to transmit.
- load_ready  out  1  transmitter can accept a word.
- d_out  out  1  serial bit stream.
- bit_strobe  out  1  one-cycle pulse in the first cycle a new bit is on d_out.
- busy  out  1  word in transmission.
- done  out  1  one-cycle pulse after the last bit period completes.
- exp_count  out  CNT_W  present only with SERIAL_TX_EXPECT_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, d_out=0, bit_strobe=0, busy=0, done=0, load_ready=1, shift register/div counter/bit counter=0, exp_count=0. Takes effect immediately, mid-word included. Any partial word is discarded.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, busy=0.
  - A handshake (load_valid & load_ready at a rising edge) loads the shift register.
  - At that same edge: d_out<=load_data[WIDTH-1], bit_strobe<=1, div_cnt<=0, bit_cnt<=0, state<=SHIFT.
- SHIFT:
  - load_ready=0, busy=1. load_valid is ignored and load_data is not sampled.
  - div_cnt increments each clk.
  - When div_cnt==DIV-1 and bit_cnt<WIDTH-1: div_cnt<=0, bit_cnt++, d_out<=next bit (MSB-first), bit_strobe<=1 for that cycle.
  - When div_cnt==DIV-1 and bit_cnt==WIDTH-1: state<=IDLE, done<=1 for one cycle, d_out holds the last bit.
- Timing:
  - First bit appears the cycle after the accept edge.
  - busy is high for exactly WIDTH*DIV cycles.
  - done is high in the first IDLE cycle, with load_ready=1 in that same cycle.
- Back-to-back: a word presented in the done cycle is accepted at that edge. The last bit is therefore held DIV+1 cycles, a one-cycle gap between words.
- Idle line: d_out holds the last transmitted bit; it is 0 only after reset. No glitches are allowed between bits.
- DIV=1: a new bit every clk and bit_strobe continuously high during SHIFT.
- Counters: div_cnt width clog2(DIV)+1, bit_cnt width clog2(WIDTH)+1. No wrap inside a word.

Optional Feature:
- Macro SERIAL_TX_EXPECT_EN.
- Defined:
  - Shadow 4-bit history register shifts in each bit as it is driven. History persists across words and is cleared only by reset.
  - Once 4 or more bits have been sent since reset, exp_count increments (saturating at 2^CNT_W-1) in the cycle after bit_strobe whenever history equals 0101 or 1010.
  - This gives the bench/board a golden detection count to compare against the detector's pulses.
- Not defined: exp_count port and the history logic are absent. All other behaviour is identical.

Test Plan:
- Reset check: reset=0 -> d_out=0, load_ready=1, busy=0, done=0, bit_strobe=0. Release reset -> values unchanged until a load.
- Load 8'hA5 (DIV=4) -> d_out = 1,0,1,0,0,1,0,1, each held 4 clk. 8 bit_strobe pulses spaced 4 clk apart. busy high for 32 clk. done pulses once, 32 clk after the accept edge.
- Busy lockout: during the 8'hA5 transfer hold load_valid=1 with 8'hFF -> load_ready=0 and the stream is unaffected. 8'hFF is accepted at the done edge; its first bit appears one cycle after the done cycle.
- Mid-word reset: assert reset during bit 3 of 8'h3C -> outputs go to reset values immediately. After release, load 8'hC3 -> stream restarts from the MSB: 1,1,0,0,0,0,1,1.
- DIV=1, WIDTH=8, load_valid held high with 8'h0F -> bits change every clk. bit_strobe high for 8 consecutive cycles. One-cycle idle (done) between words.
- SERIAL_TX_EXPECT_EN: from reset send 8'h5A -> exp_count=2. Then send 8'h55 -> exp_count=7.
